// File: rtl/nios_oci_trace_capture.sv
// Trace-capture buffer for the Nios II OCI debug trace path.
// Circular store of {dct_count, dct_buffer} entries, with stop-when-full or
// overwrite-oldest behaviour, a saturating lost-entry counter, and an
// end-of-test freeze. A show-ahead valid/ready port drains the stored entries.
module nios_oci_trace_capture #(
  parameter  int DATA_W = 30,
  parameter  int CNT_W  = 4,
  parameter  int DEPTH  = 16,
  parameter  int OVF_W  = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int EW     = CNT_W + DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] dct_buffer,
  input  logic [CNT_W-1:0]  dct_count,
  input  logic              dct_valid,
  input  logic              test_ending,
  input  logic              test_has_ended,
  input  logic              cfg_wrap,
  input  logic              clear,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [EW-1:0]     rd_data,
  output logic [AW:0]       fill_level,
  output logic [OVF_W-1:0]  overflow_cnt,
  output logic [1:0]        state,
  output logic              capture_done
);

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_ENDING  = 2'd1,
    ST_FROZEN  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_fill;
  logic [OVF_W-1:0] r_ovf;
  state_t           r_state;
  logic             r_done;

  logic             w_capt, w_wr, w_pop, w_full;
  logic             w_store, w_lost, w_adv_rd;
  logic [AW:0]      w_fill_nxt;
  state_t           w_state_nxt;

  // Write is qualified by a non-empty entry and a capturing state; clear
  // swallows any entry offered in the same cycle.
  assign w_capt   = (r_state == ST_CAPTURE) || (r_state == ST_ENDING);
  assign w_wr     = dct_valid && (dct_count != '0) && w_capt && !clear;
  assign rd_valid = (r_fill != '0);
  assign w_pop    = rd_valid && rd_ready;
  assign w_full   = (r_fill == L_FULL);

  // A pop frees a slot in the same cycle, so a full buffer with a pop still
  // takes the write; without a pop, only wrap mode stores (over the head).
  assign w_store  = w_wr && (!w_full || w_pop || cfg_wrap);
  assign w_lost   = w_wr && w_full && !w_pop;
  assign w_adv_rd = w_pop || (w_lost && cfg_wrap);

  // Occupancy after this cycle's write/pop.
  always_comb begin
    w_fill_nxt = r_fill;
    if (w_store && !w_pop && !w_full)
      w_fill_nxt = r_fill + (AW+1)'(1);
    else if (w_pop && !w_store)
      w_fill_nxt = r_fill - (AW+1)'(1);
  end

  // End-of-test sequencing; has_ended outranks ending, DONE is sticky.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CAPTURE: begin
        if (test_has_ended)   w_state_nxt = ST_FROZEN;
        else if (test_ending) w_state_nxt = ST_ENDING;
      end
      ST_ENDING:  if (test_has_ended)      w_state_nxt = ST_FROZEN;
      ST_FROZEN:  if (w_fill_nxt == '0)    w_state_nxt = ST_DONE;
      default:    w_state_nxt = ST_DONE;
    endcase
  end

  // Entry storage; contents are don't-care until written, rd_data is gated.
  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wptr] <= {dct_count, dct_buffer};
  end

  // Pointers, occupancy, overflow counter and state; clear beats everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_fill  <= '0;
      r_ovf   <= '0;
      r_state <= ST_CAPTURE;
      r_done  <= 1'b0;
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_fill  <= '0;
      r_ovf   <= '0;
      r_state <= ST_CAPTURE;
      r_done  <= 1'b0;
    end else begin
      if (w_store)  r_wptr <= r_wptr + AW'(1);
      if (w_adv_rd) r_rptr <= r_rptr + AW'(1);
      if (w_lost && !(&r_ovf)) r_ovf <= r_ovf + OVF_W'(1);
      r_fill  <= w_fill_nxt;
      r_state <= w_state_nxt;
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  assign rd_data      = rd_valid ? r_mem[r_rptr] : '0;
  assign fill_level   = r_fill;
  assign overflow_cnt = r_ovf;
  assign state        = r_state;
  assign capture_done = r_done;

endmodule

// File: tb/tb_nios_oci_trace_capture.sv
// Bench for nios_oci_trace_capture: a queue-based model of the trace buffer
// is checked against two instances (16-bit and 2-bit overflow counters) on
// every falling edge, plus directed scenarios with literal expectations.
module tb_nios_oci_trace_capture;
  localparam int DW = 30, CW = 4, DEPTH = 16, EW = CW + DW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [DW-1:0] dct_buffer = '0;
  logic [CW-1:0] dct_count = '0;
  logic          dct_valid = 1'b0, test_ending = 1'b0, test_has_ended = 1'b0;
  logic          cfg_wrap = 1'b0, clear = 1'b0, rd_ready = 1'b0;

  logic          rd_valid, s_rd_valid, capture_done, s_capture_done;
  logic [EW-1:0] rd_data, s_rd_data;
  logic [4:0]    fill_level, s_fill_level;
  logic [15:0]   overflow_cnt;
  logic [1:0]    s_overflow_cnt, state, s_state;

  nios_oci_trace_capture #(.DATA_W(DW), .CNT_W(CW), .DEPTH(DEPTH), .OVF_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .cfg_wrap(cfg_wrap), .clear(clear), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .fill_level(fill_level), .overflow_cnt(overflow_cnt),
    .state(state), .capture_done(capture_done));

  nios_oci_trace_capture #(.DATA_W(DW), .CNT_W(CW), .DEPTH(DEPTH), .OVF_W(2)) u_sat (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .cfg_wrap(cfg_wrap), .clear(clear), .rd_ready(rd_ready), .rd_valid(s_rd_valid),
    .rd_data(s_rd_data), .fill_level(s_fill_level), .overflow_cnt(s_overflow_cnt),
    .state(s_state), .capture_done(s_capture_done));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: the buffer is just a queue of entries.
  logic [EW-1:0] mq[$];
  int m_ovf = 0;
  int m_st  = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete(); m_ovf = 0; m_st = 0;
    end else if (clear) begin
      mq.delete(); m_ovf = 0; m_st = 0;
    end else begin
      bit pop, wr;
      int old_st;
      pop = (mq.size() > 0) && rd_ready;
      wr  = dct_valid && (dct_count != 0) && (m_st < 2);
      if (pop) void'(mq.pop_front());
      if (wr) begin
        if (mq.size() < DEPTH) mq.push_back({dct_count, dct_buffer});
        else begin
          m_ovf++;
          if (cfg_wrap) begin
            void'(mq.pop_front());
            mq.push_back({dct_count, dct_buffer});
          end
        end
      end
      old_st = m_st;
      if (old_st < 2 && test_has_ended)    m_st = 2;
      else if (old_st == 0 && test_ending) m_st = 1;
      else if (old_st == 2 && mq.size() == 0) m_st = 3;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [EW-1:0] e_data;
    e_data = (mq.size() > 0) ? mq[0] : '0;
    check("rd_valid", rd_valid, mq.size() > 0);
    check("rd_data", rd_data, e_data);
    check("fill_level", fill_level, mq.size());
    check("overflow_cnt", overflow_cnt, (m_ovf > 65535) ? 65535 : m_ovf);
    check("state", state, m_st);
    check("capture_done", capture_done, m_st == 3);
    check("sat_rd_data", s_rd_data, e_data);
    check("sat_fill", s_fill_level, mq.size());
    check("sat_overflow_cnt", s_overflow_cnt, (m_ovf > 3) ? 3 : m_ovf);
    check("sat_state", s_state, m_st);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [CW-1:0] c, input logic [DW-1:0] d);
    dct_valid = 1'b1; dct_count = c; dct_buffer = d;
    step();
    dct_valid = 1'b0;
  endtask

  task automatic clr();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  initial begin
    logic [EW-1:0] e;
    #1 reset_n = 1'b0;
    @(negedge clk); #1;
    check("rst_state", state, 0);
    check("rst_fill", fill_level, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_ovf", overflow_cnt, 0);
    check("rst_done", capture_done, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Fill and drain
    for (int i = 0; i < 5; i++) wr(CW'(i + 1), DW'(32'h100 + i));
    e = {4'd1, 30'h100};
    check("fill5", fill_level, 5);
    check("fill5_ovf", overflow_cnt, 0);
    check("fill5_head", rd_data, e);
    rd_ready = 1'b1; repeat (5) step(); rd_ready = 1'b0;
    check("drained_valid", rd_valid, 0);

    // Stop-when-full
    clr(); cfg_wrap = 1'b0;
    for (int i = 0; i < 20; i++) wr(CW'(1 + i % 15), DW'(i));
    check("stop_fill", fill_level, 16);
    check("stop_ovf", overflow_cnt, 4);
    check("stop_sat_ovf", s_overflow_cnt, 3);
    check("stop_head", rd_data[DW-1:0], 0);
    rd_ready = 1'b1; step();
    check("stop_head2", rd_data[DW-1:0], 1);
    repeat (15) step(); rd_ready = 1'b0;
    check("stop_empty", fill_level, 0);

    // Wrap mode, then full with simultaneous pop and write
    clr(); cfg_wrap = 1'b1;
    for (int i = 0; i < 20; i++) wr(CW'(1 + i % 15), DW'(i));
    check("wrap_fill", fill_level, 16);
    check("wrap_ovf", overflow_cnt, 4);
    check("wrap_head", rd_data[DW-1:0], 4);
    rd_ready = 1'b1; dct_valid = 1'b1; dct_count = 4'd1; dct_buffer = 30'd99;
    step(); dct_valid = 1'b0;
    check("wrap_popwr_ovf", overflow_cnt, 4);
    check("wrap_popwr_fill", fill_level, 16);
    check("wrap_popwr_head", rd_data[DW-1:0], 5);
    repeat (16) step(); rd_ready = 1'b0;
    check("wrap_empty", fill_level, 0);

    // End-of-test sequence
    clr(); cfg_wrap = 1'b0;
    for (int i = 0; i < 3; i++) wr(4'd2, DW'(i));
    test_ending = 1'b1; step(); test_ending = 1'b0;
    check("eot_ending", state, 1);
    test_has_ended = 1'b1; dct_valid = 1'b1; dct_count = 4'd7; dct_buffer = 30'h3A;
    step();
    check("eot_frozen", state, 2);
    check("eot_last_stored", fill_level, 4);
    repeat (3) step();
    dct_valid = 1'b0;
    check("eot_ignored", fill_level, 4);
    rd_ready = 1'b1; repeat (3) step();
    e = {4'd7, 30'h3A};
    check("eot_last_entry", rd_data, e);
    check("eot_still_frozen", state, 2);
    step(); rd_ready = 1'b0;
    check("eot_done_state", state, 3);
    check("eot_done_flag", capture_done, 1);

    // Clear in DONE with an entry offered; has_ended still high
    dct_valid = 1'b1; dct_count = 4'd5; clear = 1'b1; step();
    clear = 1'b0; dct_valid = 1'b0;
    check("clr_state", state, 0);
    check("clr_fill", fill_level, 0);
    check("clr_ovf", overflow_cnt, 0);
    check("clr_rd_valid", rd_valid, 0);
    step();
    check("clr_refreeze", state, 2);
    test_has_ended = 1'b0; step();
    check("clr_redone", state, 3);
    clr();
    check("clr_rearm", state, 0);

    // Zero-count filter and saturation
    wr(4'd0, 30'h55);
    check("zero_not_stored", fill_level, 0);
    for (int i = 0; i < 16; i++) wr(4'd3, DW'(i));
    wr(4'd0, 30'h55);
    check("zero_full_ovf", overflow_cnt, 0);
    for (int i = 0; i < 10; i++) wr(4'd1, DW'(i));
    check("sat_main_ovf", overflow_cnt, 10);
    check("sat_ovf_hold", s_overflow_cnt, 3);

    // Reset mid-burst
    dct_valid = 1'b1; dct_count = 4'd1; reset_n = 1'b0; #1;
    check("mid_rst_fill", fill_level, 0);
    check("mid_rst_ovf", overflow_cnt, 0);
    check("mid_rst_valid", rd_valid, 0);
    check("mid_rst_data", rd_data, 0);
    check("mid_rst_state", state, 0);
    step(); step(); reset_n = 1'b1; dct_valid = 1'b0;

    // Randomized traffic
    for (int seg = 0; seg < 8; seg++) begin
      int rdp;
      rdp = $urandom_range(1, 6);
      cfg_wrap = 1'($urandom_range(0, 1));
      for (int c = 0; c < 250; c++) begin
        dct_valid  = ($urandom_range(0, 3) != 0);
        dct_count  = 4'($urandom_range(0, 3));
        dct_buffer = 30'($urandom);
        rd_ready   = ($urandom_range(0, 7) < rdp);
        clear      = ($urandom_range(0, 79) == 0);
        test_ending = ($urandom_range(0, 40) == 0);
        if ($urandom_range(0, 120) == 0) test_has_ended = ~test_has_ended;
        if ($urandom_range(0, 400) == 0) begin
          reset_n = 1'b0; #2 reset_n = 1'b1;
        end
        step();
      end
    end
    dct_valid = 1'b0; clear = 1'b0; rd_ready = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
